pipe_ctrl_sched: RTL and testbench

Pipeline control scheduler for the 5-stage RV32I core. It takes the decode-stage control bundle from the main decoder and carries it through the ID/EX, EX/MEM and MEM/WB control registers. It detects load-use and memory-wait hazards and generates stall, flush and forwarding selects. It also sequences the data-memory ready handshake, with a timeout.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_ctrl_sched_if.sv | 42 ++++
 rtl/fwd_sel.sv | 24 ++
 rtl/pipe_ctrl_sched.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl_sched.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control scheduler: control bundle
// layout, result-source and forward-select encodings.
package pipe_ctrl_pkg;

  localparam int CTRL_W = 10;

  // Decoded control bundle. Field order fixes the bit offsets (MSB first):
  // [9] reg_write, [8] alu_src, [7] mem_write, [6:5] result_src,
  // [4] branch, [3] jump, [2:1] alu_op, [0] spare.
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       spare;
  } ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

endpackage

// File: rtl/pipe_ctrl_sched_if.sv
// Decode-side inputs and hazard/pipeline-register outputs of the scheduler.
interface pipe_ctrl_sched_if;
  import pipe_ctrl_pkg::*;

  ctrl_t      ctrl_d;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] RdD;
  logic       PCSrcE;
  logic       dmem_ready;

  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  ctrl_t      ctrl_e;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  ctrl_t      ctrl_m;
  logic [4:0] RdM;
  logic       RegWriteW;
  logic [1:0] ResultSrcW;
  logic [4:0] RdW;
  logic       mem_err;

  modport master (
    output ctrl_d, Rs1D, Rs2D, RdD, PCSrcE, dmem_ready,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           ctrl_e, Rs1E, Rs2E, RdE, ctrl_m, RdM,
           RegWriteW, ResultSrcW, RdW, mem_err
  );

  modport slave (
    input  ctrl_d, Rs1D, Rs2D, RdD, PCSrcE, dmem_ready,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           ctrl_e, Rs1E, Rs2E, RdE, ctrl_m, RdM,
           RegWriteW, ResultSrcW, RdW, mem_err
  );
endinterface

// File: rtl/fwd_sel.sv
// Forward select for one E-stage source operand; MEM stage wins over WB.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic       i_v_m,
  input  logic       i_regwrite_m,
  input  logic [4:0] i_rd_m,
  input  logic       i_v_w,
  input  logic       i_regwrite_w,
  input  logic [4:0] i_rd_w,
  output logic [1:0] o_fwd
);

  // x0 is hardwired zero, so a write to it never forwards
  always_comb begin
    o_fwd = FWD_RF;
    if (i_v_m && i_regwrite_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs))
      o_fwd = FWD_MEM;
    else if (i_v_w && i_regwrite_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs))
      o_fwd = FWD_WB;
  end

endmodule

// File: rtl/pipe_ctrl_sched.sv
// Pipeline control scheduler for the 5-stage RV32I core: carries the decoded
// control bundle through ID/EX, EX/MEM and MEM/WB, detects load-use and
// data-memory wait hazards, and produces stall/flush/forward controls.
module pipe_ctrl_sched
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_ctrl_sched_if.slave bus
);

  ctrl_t      r_ctrl_e;
  logic [4:0] r_rs1_e;
  logic [4:0] r_rs2_e;
  logic [4:0] r_rd_e;
  logic       r_v_e;
  ctrl_t      r_ctrl_m;
  logic [4:0] r_rd_m;
  logic       r_v_m;
  logic       r_regwrite_w;
  logic [1:0] r_ressrc_w;
  logic [4:0] r_rd_w;
  logic       r_v_w;
  logic [7:0] r_wait_cnt;

  logic w_mem_acc;
  logic w_timeout;
  logic w_mem_wait;
  logic w_mem_err;
  logic w_lw_hazard;
  logic w_flush_e;

  assign w_mem_acc  = r_v_m && (r_ctrl_m.mem_write || (r_ctrl_m.result_src == RES_MEM));
  assign w_timeout  = (r_wait_cnt == 8'(MEM_TIMEOUT - 1));
  assign w_mem_wait = w_mem_acc && !bus.dmem_ready && !w_timeout;
  assign w_mem_err  = w_mem_acc && !bus.dmem_ready && w_timeout;

  // A taken branch/jump in E flushes D anyway, so the load-use stall is
  // dropped to let the PC take the target.
  assign w_lw_hazard = r_v_e && (r_ctrl_e.result_src == RES_MEM) && (r_rd_e != 5'd0) &&
                       ((r_rd_e == bus.Rs1D) || (r_rd_e == bus.Rs2D)) && !bus.PCSrcE;
  assign w_flush_e   = (w_lw_hazard || bus.PCSrcE) && !w_mem_wait;

  // Flushes are gated by rst so every output reads 0 while reset is held,
  // even if PCSrcE is driven high.
  assign bus.StallF     = w_lw_hazard || w_mem_wait;
  assign bus.StallD     = w_lw_hazard || w_mem_wait;
  assign bus.FlushD     = rst && bus.PCSrcE && !w_mem_wait;
  assign bus.FlushE     = rst && w_flush_e;
  assign bus.mem_err    = w_mem_err;
  assign bus.ctrl_e     = r_ctrl_e;
  assign bus.Rs1E       = r_rs1_e;
  assign bus.Rs2E       = r_rs2_e;
  assign bus.RdE        = r_rd_e;
  assign bus.ctrl_m     = r_ctrl_m;
  assign bus.RdM        = r_rd_m;
  assign bus.RegWriteW  = r_regwrite_w;
  assign bus.ResultSrcW = r_ressrc_w;
  assign bus.RdW        = r_rd_w;

  // ID/EX and EX/MEM advance together; both freeze while MEM waits on memory
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl_e <= '0;
      r_rs1_e  <= '0;
      r_rs2_e  <= '0;
      r_rd_e   <= '0;
      r_v_e    <= 1'b0;
      r_ctrl_m <= '0;
      r_rd_m   <= '0;
      r_v_m    <= 1'b0;
    end else if (!w_mem_wait) begin
      if (w_flush_e) begin
        r_ctrl_e <= '0;
        r_rs1_e  <= '0;
        r_rs2_e  <= '0;
        r_rd_e   <= '0;
        r_v_e    <= 1'b0;
      end else begin
        r_ctrl_e <= bus.ctrl_d;
        r_rs1_e  <= bus.Rs1D;
        r_rs2_e  <= bus.Rs2D;
        r_rd_e   <= bus.RdD;
        r_v_e    <= 1'b1;
      end
      r_ctrl_m <= r_ctrl_e;
      r_rd_m   <= r_rd_e;
      r_v_m    <= r_v_e;
    end
  end

  // MEM/WB takes a bubble during a wait; a timed-out access retires without writing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regwrite_w <= 1'b0;
      r_ressrc_w   <= '0;
      r_rd_w       <= '0;
      r_v_w        <= 1'b0;
    end else if (w_mem_wait) begin
      r_regwrite_w <= 1'b0;
      r_ressrc_w   <= '0;
      r_rd_w       <= '0;
      r_v_w        <= 1'b0;
    end else begin
      r_regwrite_w <= r_v_m && r_ctrl_m.reg_write && !w_mem_err;
      r_ressrc_w   <= r_ctrl_m.result_src;
      r_rd_w       <= r_rd_m;
      r_v_w        <= r_v_m;
    end
  end

  // Counts consecutive wait cycles; any non-waiting cycle means the access left M or completed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_wait_cnt <= '0;
    else if (w_mem_wait)
      r_wait_cnt <= r_wait_cnt + 8'd1;
    else
      r_wait_cnt <= '0;
  end

  fwd_sel u_fwd_a (
    .i_rs         (r_rs1_e),
    .i_v_m        (r_v_m),
    .i_regwrite_m (r_ctrl_m.reg_write),
    .i_rd_m       (r_rd_m),
    .i_v_w        (r_v_w),
    .i_regwrite_w (r_regwrite_w),
    .i_rd_w       (r_rd_w),
    .o_fwd        (bus.ForwardAE)
  );

  fwd_sel u_fwd_b (
    .i_rs         (r_rs2_e),
    .i_v_m        (r_v_m),
    .i_regwrite_m (r_ctrl_m.reg_write),
    .i_rd_m       (r_rd_m),
    .i_v_w        (r_v_w),
    .i_regwrite_w (r_regwrite_w),
    .i_rd_w       (r_rd_w),
    .o_fwd        (bus.ForwardBE)
  );

endmodule

// File: tb/tb_pipe_ctrl_sched.sv
// Directed bench for pipe_ctrl_sched (MEM_TIMEOUT = 4): load-use stall,
// forwarding priority, branch flush, memory wait with held branch, timeout,
// and reset during a memory wait.
module tb_pipe_ctrl_sched;

  // Control bundles: {RegWrite, ALUSrc, MemWrite, ResultSrc[1:0], Branch, Jump, ALUOp[1:0], spare}
  localparam int LW  = 'h320;
  localparam int ADD = 'h204;
  localparam int SW  = 'h180;
  localparam int BEQ = 'h012;
  localparam int NOP = 0;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_ctrl_sched_if bus();

  pipe_ctrl_sched #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic flags(input string tag, input int sf, input int fd, input int fe);
    check_eq({tag, "_stallf"}, 32'(bus.StallF), sf);
    check_eq({tag, "_stalld"}, 32'(bus.StallD), sf);
    check_eq({tag, "_flushd"}, 32'(bus.FlushD), fd);
    check_eq({tag, "_flushe"}, 32'(bus.FlushE), fe);
  endtask

  task automatic pres(input int c, input int r1, input int r2, input int rd);
    bus.ctrl_d = 10'(c);
    bus.Rs1D   = 5'(r1);
    bus.Rs2D   = 5'(r2);
    bus.RdD    = 5'(rd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      pres(NOP, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with live-looking inputs: everything must read 0
    rst = 1'b0;
    bus.PCSrcE = 1'b1;
    bus.dmem_ready = 1'b1;
    pres(LW, 5, 5, 5);
    #2;
    flags("rst", 0, 0, 0);
    check_eq("rst_ctrl_e", 32'(bus.ctrl_e), 0);
    check_eq("rst_ctrl_m", 32'(bus.ctrl_m), 0);
    check_eq("rst_regwritew", 32'(bus.RegWriteW), 0);
    check_eq("rst_fwda", 32'(bus.ForwardAE), 0);
    check_eq("rst_memerr", 32'(bus.mem_err), 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_ctrl_e", 32'(bus.ctrl_e), 0);
    check_eq("rst_hold_rde", 32'(bus.RdE), 0);
    rst = 1'b1;
    bus.PCSrcE = 1'b0;

    // T1: lw x5 ; add x6,x5,x1 -> one stall cycle, then WB forward
    pres(LW, 1, 0, 5);
    #1; flags("t1_a", 0, 0, 0);
    tick();
    pres(ADD, 5, 1, 6);
    #1; flags("t1_b", 1, 0, 1);
    check_eq("t1_ctrl_e", 32'(bus.ctrl_e), LW);
    check_eq("t1_rde", 32'(bus.RdE), 5);
    tick();
    #1; flags("t1_c", 0, 0, 0);
    check_eq("t1_bubble_e", 32'(bus.ctrl_e), 0);
    tick();
    pres(NOP, 0, 0, 0);
    #1;
    check_eq("t1_fwda", 32'(bus.ForwardAE), 1);
    check_eq("t1_fwdb", 32'(bus.ForwardBE), 0);
    check_eq("t1_rdw", 32'(bus.RdW), 5);
    check_eq("t1_ressrcw", 32'(bus.ResultSrcW), 1);
    check_eq("t1_regwritew", 32'(bus.RegWriteW), 1);
    tick();
    nops(3);

    // T2: add x5 ; add x5 ; sub x7,x5,x5 -> MEM forward beats WB, no stall
    pres(ADD, 3, 4, 5);
    tick();
    pres(ADD, 1, 2, 5);
    #1; flags("t2_a", 0, 0, 0);
    tick();
    pres(ADD, 5, 5, 7);
    #1; flags("t2_b", 0, 0, 0);
    tick();
    pres(NOP, 0, 0, 0);
    #1;
    check_eq("t2_fwda", 32'(bus.ForwardAE), 2);
    check_eq("t2_fwdb", 32'(bus.ForwardBE), 2);
    check_eq("t2_stallf", 32'(bus.StallF), 0);
    tick();
    // x0 never stalls or forwards
    pres(LW, 1, 0, 0);
    tick();
    pres(ADD, 0, 0, 8);
    #1; flags("t2_x0", 0, 0, 0);
    tick();
    pres(NOP, 0, 0, 0);
    #1;
    check_eq("t2_x0_fwda", 32'(bus.ForwardAE), 0);
    check_eq("t2_x0_fwdb", 32'(bus.ForwardBE), 0);
    tick();
    nops(3);

    // T3: taken branch while a load-use pattern is in D -> flush, no stall
    pres(LW, 1, 0, 5);
    tick();
    pres(ADD, 5, 1, 6);
    bus.PCSrcE = 1'b1;
    #1; flags("t3", 0, 1, 1);
    tick();
    bus.PCSrcE = 1'b0;
    pres(NOP, 0, 0, 0);
    #1; flags("t3_after", 0, 0, 0);
    check_eq("t3_bubble_e", 32'(bus.ctrl_e), 0);
    tick();
    nops(2);

    // T4: add x11 ; sw ; beq, sw waits 3 cycles with the branch taken in E
    pres(ADD, 1, 2, 11);
    tick();
    pres(SW, 1, 2, 0);
    tick();
    pres(BEQ, 3, 4, 0);
    tick();
    pres(ADD, 1, 2, 10);
    bus.PCSrcE = 1'b1;
    bus.dmem_ready = 1'b0;
    #1; flags("t4_w0", 1, 0, 0);
    check_eq("t4_w0_regwritew", 32'(bus.RegWriteW), 1);
    check_eq("t4_w0_rdw", 32'(bus.RdW), 11);
    tick();
    for (int i = 1; i < 3; i++) begin
      #1; flags("t4_w", 1, 0, 0);
      check_eq("t4_w_ctrl_e", 32'(bus.ctrl_e), BEQ);
      check_eq("t4_w_ctrl_m", 32'(bus.ctrl_m), SW);
      check_eq("t4_w_regwritew", 32'(bus.RegWriteW), 0);
      check_eq("t4_w_rdw", 32'(bus.RdW), 0);
      check_eq("t4_w_memerr", 32'(bus.mem_err), 0);
      tick();
    end
    bus.dmem_ready = 1'b1;
    #1; flags("t4_rel", 0, 1, 1);
    tick();
    bus.PCSrcE = 1'b0;
    pres(NOP, 0, 0, 0);
    #1;
    check_eq("t4_post_ctrl_e", 32'(bus.ctrl_e), 0);
    check_eq("t4_post_ctrl_m", 32'(bus.ctrl_m), BEQ);
    check_eq("t4_post_regwritew", 32'(bus.RegWriteW), 0);
    tick();
    nops(2);

    // T5: load x12 with memory never ready -> 3 wait cycles, timeout on the 4th
    pres(LW, 1, 0, 12);
    tick();
    pres(NOP, 0, 0, 0);
    tick();
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t5_wait_stallf", 32'(bus.StallF), 1);
      check_eq("t5_wait_memerr", 32'(bus.mem_err), 0);
      tick();
    end
    #1;
    check_eq("t5_to_stallf", 32'(bus.StallF), 0);
    check_eq("t5_to_memerr", 32'(bus.mem_err), 1);
    tick();
    #1;
    check_eq("t5_post_memerr", 32'(bus.mem_err), 0);
    check_eq("t5_post_regwritew", 32'(bus.RegWriteW), 0);
    check_eq("t5_post_rdw", 32'(bus.RdW), 12);
    check_eq("t5_post_ressrcw", 32'(bus.ResultSrcW), 1);
    bus.dmem_ready = 1'b1;
    tick();
    nops(2);

    // T6: reset asserted mid-wait, then the first instruction after release
    pres(LW, 1, 0, 13);
    tick();
    pres(NOP, 0, 0, 0);
    tick();
    bus.dmem_ready = 1'b0;
    #1; check_eq("t6_wait_stallf", 32'(bus.StallF), 1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_stallf", 32'(bus.StallF), 0);
    check_eq("t6_rst_ctrl_e", 32'(bus.ctrl_e), 0);
    check_eq("t6_rst_ctrl_m", 32'(bus.ctrl_m), 0);
    check_eq("t6_rst_rdm", 32'(bus.RdM), 0);
    check_eq("t6_rst_memerr", 32'(bus.mem_err), 0);
    tick();
    tick();
    rst = 1'b1;
    bus.dmem_ready = 1'b1;
    pres(ADD, 1, 2, 14);
    #1; check_eq("t6_pre_ctrl_e", 32'(bus.ctrl_e), 0);
    tick();
    pres(NOP, 0, 0, 0);
    #1;
    check_eq("t6_ctrl_e", 32'(bus.ctrl_e), ADD);
    check_eq("t6_rde", 32'(bus.RdE), 14);
    check_eq("t6_memerr", 32'(bus.mem_err), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
